// File: rtl/pll_pkg.sv
// pll_pkg: shared defaults and transmit FSM state type for the BPSK NCO datapath.
package pll_pkg;
    localparam int PHASE_BITS_DEF = 32;
    localparam int DATA_BITS_DEF  = 8;
    localparam int SYNC_BITS_DEF  = 4;
    typedef enum logic [1:0] {IDLE, SYNC, START, DATA} tx_state_t;
endpackage

// File: rtl/bpsk_nco_tx_if.sv
// bpsk_nco_tx_if: payload valid/ready handshake into the BPSK transmitter.
interface bpsk_nco_tx_if import pll_pkg::*; #(
    parameter int DATA_BITS = DATA_BITS_DEF
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    modport master(output tx_valid, tx_data, input tx_ready);
    modport slave(input tx_valid, tx_data, output tx_ready);
endinterface

// File: rtl/nco_accum.sv
// nco_accum: phase accumulator with loadable step; shared by the transmitter and the receive PLL.
module nco_accum #(
    parameter int                    PHASE_BITS         = 32,
    parameter logic [PHASE_BITS-1:0] INITIAL_PHASE_STEP = '0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  load,
    input  logic [PHASE_BITS-2:0] freq,
    output logic [PHASE_BITS-1:0] phase
);
    logic [PHASE_BITS-1:0] step_q, step_d, phase_q, phase_d;
    // the increment always uses the step held before a same-cycle load
    always_comb begin
        step_d  = load ? {1'b0, freq} : step_q;
        phase_d = en ? phase_q + step_q : phase_q;
    end
    always_ff @(posedge clk) begin
        if (!nrst) begin
            step_q  <= INITIAL_PHASE_STEP;
            phase_q <= '0;
        end else begin
            step_q  <= step_d;
            phase_q <= phase_d;
        end
    end
    assign phase = phase_q;
endmodule

// File: rtl/bpsk_nco_tx.sv
// bpsk_nco_tx: BPSK transmitter; NCO square carrier inverted by a sync/start/data symbol stream.
module bpsk_nco_tx import pll_pkg::*; #(
    parameter int                    PHASE_BITS         = PHASE_BITS_DEF,
    parameter int                    DATA_BITS          = DATA_BITS_DEF,
    parameter int                    SYNC_BITS          = SYNC_BITS_DEF,
    parameter logic [PHASE_BITS-1:0] INITIAL_PHASE_STEP = '0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  swiptAlive,
    input  logic                  load_freq,
    input  logic [PHASE_BITS-2:0] freq,
    input  logic [15:0]           bit_len,
    bpsk_nco_tx_if.slave          tx,
    output logic                  carrier_out,
    output logic [PHASE_BITS-1:0] phase,
    output logic                  busy
);
    localparam int CW = $clog2(SYNC_BITS > DATA_BITS ? SYNC_BITS : DATA_BITS) + 1;
    localparam logic [CW-1:0] LAST_SYNC = CW'(SYNC_BITS - 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
    tx_state_t            state_q, state_d;
    logic [15:0]          bit_cnt_q, bit_cnt_d, bit_len_q, bit_len_d;
    logic [CW-1:0]        sym_cnt_q, sym_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 boundary, last_sym, accept, sym;
    nco_accum #(.PHASE_BITS(PHASE_BITS), .INITIAL_PHASE_STEP(INITIAL_PHASE_STEP)) u_accum (
        .clk   (clk),
        .nrst  (nrst),
        .en    (swiptAlive),
        .load  (load_freq),
        .freq  (freq),
        .phase (phase)
    );
    // a zero bit length behaves as one cycle per symbol
    assign boundary    = bit_cnt_q == ((bit_len_q == 16'd0) ? 16'd0 : bit_len_q - 16'd1);
    assign last_sym    = state_q == DATA && boundary && sym_cnt_q == LAST_DATA;
    assign tx.tx_ready = nrst && swiptAlive && (state_q == IDLE || last_sym);
    assign accept      = tx.tx_valid && tx.tx_ready;
    assign sym         = state_q == START || (state_q == DATA && shift_q[DATA_BITS-1]);
    assign carrier_out = nrst && (phase[PHASE_BITS-1] ^ sym);
    assign busy        = nrst && state_q != IDLE;
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sym_cnt_d = sym_cnt_q;
        shift_d   = shift_q;
        bit_len_d = bit_len_q;
        if (swiptAlive) begin
            if (state_q == IDLE) begin
                if (accept) begin
                    state_d   = SYNC;
                    shift_d   = tx.tx_data;
                    bit_len_d = bit_len;
                end
            end else begin
                bit_cnt_d = boundary ? 16'd0 : bit_cnt_q + 16'd1;
                if (boundary) begin
                    sym_cnt_d = sym_cnt_q + CW'(1);
                    case (state_q)
                        SYNC: if (sym_cnt_q == LAST_SYNC) begin
                            state_d   = START;
                            sym_cnt_d = '0;
                        end
                        START: begin
                            state_d   = DATA;
                            sym_cnt_d = '0;
                        end
                        DATA: if (last_sym) begin
                            state_d   = accept ? START : IDLE;
                            sym_cnt_d = '0;
                            shift_d   = accept ? tx.tx_data : shift_q;
                        end else begin
                            shift_d = shift_q << 1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sym_cnt_q <= '0;
            shift_q   <= '0;
            bit_len_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sym_cnt_q <= sym_cnt_d;
            shift_q   <= shift_d;
            bit_len_q <= bit_len_d;
        end
    end
endmodule
